// File: rtl/half_band_decim_2.sv
// -----------------------------------------------------------------------------
// half_band_decim_2
//
// Receive-side decimate-by-2 half-band filter, 1s17 data. Every second
// accepted sample starts a four-step multiply-accumulate sequence on one
// shared multiplier. The sequence handles the centre tap and then the three
// symmetric tap pairs, and the rounded, saturated result comes out one cycle
// after the last step.
//
// Ports
//   clk      in   1  system clock, rising edge
//   reset    in   1  synchronous, active-high reset
//   clk_en   in   1  input-sample strobe, one clk wide
//   x_in     in  18  signed 1s17 input sample, valid with clk_en
//   y        out 18  signed 1s17 decimated output, held between updates
//   y_valid  out  1  one-cycle pulse when y updates
//   busy     out  1  high while a MAC sequence is in progress
//   overrun  out  1  sticky, set when a sample arrives while busy
// -----------------------------------------------------------------------------
module half_band_decim_2 #(
    parameter logic signed [17:0] C1 = 18'sd41943,
    parameter logic signed [17:0] C3 = -18'sd10486,
    parameter logic signed [17:0] C5 = 18'sd1311
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic signed [17:0] x_in,
    output logic signed [17:0] y,
    output logic               y_valid,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CTR  = 3'd1,
        ST_M1   = 3'd2,
        ST_M3   = 3'd3,
        ST_M5   = 3'd4
    } state_t;

    // Clamp a wide signed value into the 18-bit output range.
    function automatic logic signed [17:0] sat18(input logic signed [39:0] v);
        logic signed [17:0] r;
        if (v > 40'sd131071) begin
            r = 18'sd131071;
        end else if (v < -40'sd131072) begin
            r = -18'sd131072;
        end else begin
            r = v[17:0];
        end
        return r;
    endfunction

    // Widen an 18-bit sample to the 19-bit pre-sum width.
    function automatic logic signed [18:0] sext19(input logic signed [17:0] v);
        return {v[17], v};
    endfunction

    state_t             state_r;
    logic signed [17:0] x_r [0:10];
    logic signed [39:0] acc_r;
    logic               phase_r;
    logic               out_pend_r;
    logic signed [17:0] y_r;
    logic               y_valid_r;
    logic               busy_r;
    logic               overrun_r;

    logic               accept_s;
    logic signed [17:0] coef_s;
    logic signed [18:0] presum_s;
    logic signed [36:0] product_s;
    logic signed [39:0] product_ext_s;
    logic signed [39:0] centre_s;
    logic signed [39:0] rounded_s;
    logic signed [39:0] shifted_s;

    assign y       = y_r;
    assign y_valid = y_valid_r;
    assign busy    = busy_r;
    assign overrun = overrun_r;

    // A strobe is only taken while no MAC sequence is running.
    assign accept_s = clk_en & ~busy_r;

    // Select coefficient and symmetric tap pair for the current MAC step.
    always_comb begin
        coef_s   = 18'sd0;
        presum_s = 19'sd0;
        case (state_r)
            ST_M1: begin
                coef_s   = C1;
                presum_s = sext19(x_r[4]) + sext19(x_r[6]);
            end
            ST_M3: begin
                coef_s   = C3;
                presum_s = sext19(x_r[2]) + sext19(x_r[8]);
            end
            ST_M5: begin
                coef_s   = C5;
                presum_s = sext19(x_r[0]) + sext19(x_r[10]);
            end
            default: begin
                coef_s   = 18'sd0;
                presum_s = 19'sd0;
            end
        endcase
    end

    // Shared multiplier plus accumulator-width alignment of its operands.
    always_comb begin
        product_s     = coef_s * presum_s;
        product_ext_s = {{3{product_s[36]}}, product_s};
        // Centre tap is 0.5: x5 placed at bit 16 of the s.17-scaled accumulator.
        centre_s      = {{6{x_r[5][17]}}, x_r[5], 16'd0};
        // Round half up: add half an output LSB, then arithmetic shift.
        rounded_s     = acc_r + 40'sd65536;
        shifted_s     = rounded_s >>> 17;
    end

    // Delay line and phase bit: shift only on accepted samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 11; k++) begin
                x_r[k] <= 18'sd0;
            end
            phase_r <= 1'b0;
        end else if (accept_s) begin
            for (int k = 10; k > 0; k--) begin
                x_r[k] <= x_r[k-1];
            end
            x_r[0]  <= x_in;
            phase_r <= ~phase_r;
        end else begin
            phase_r <= phase_r;
        end
    end

    // MAC sequencer: centre tap, then the three symmetric pairs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            acc_r      <= 40'sd0;
            busy_r     <= 1'b0;
            out_pend_r <= 1'b0;
        end else begin
            out_pend_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Phase-1 samples are the decimation points.
                    if (accept_s && phase_r) begin
                        state_r <= ST_CTR;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_CTR: begin
                    acc_r   <= centre_s;
                    state_r <= ST_M1;
                end
                ST_M1: begin
                    acc_r   <= acc_r + product_ext_s;
                    state_r <= ST_M3;
                end
                ST_M3: begin
                    acc_r   <= acc_r + product_ext_s;
                    state_r <= ST_M5;
                end
                ST_M5: begin
                    // busy drops here so a new sample may arrive on the output edge.
                    acc_r      <= acc_r + product_ext_s;
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    out_pend_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output register: rounded, saturated result one cycle after the last MAC.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_r       <= 18'sd0;
            y_valid_r <= 1'b0;
        end else if (out_pend_r) begin
            y_r       <= sat18(shifted_s);
            y_valid_r <= 1'b1;
        end else begin
            y_valid_r <= 1'b0;
        end
    end

    // Sticky flag for strobes that arrive while a sequence is running.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (clk_en && busy_r) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

endmodule

// File: tb/tb_half_band_decim_2.sv
// -----------------------------------------------------------------------------
// Testbench for half_band_decim_2. The reference model keeps the accepted
// samples in an array and computes each output straight from the filter
// equation with integer arithmetic.
// -----------------------------------------------------------------------------
module tb_half_band_decim_2;

    localparam int C1 = 41943;
    localparam int C3 = -10486;
    localparam int C5 = 1311;
    localparam int P  = 131071;
    localparam int N  = -131072;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               clk_en = 1'b0;
    logic signed [17:0] x_in = 18'sd0;
    logic signed [17:0] y;
    logic               y_valid;
    logic               busy;
    logic               overrun;

    int                 n_err = 0;
    int                 n_chk = 0;

    // Reference model state.
    int                 hist [11];
    int                 ph_m;
    logic signed [17:0] last_y;
    bit                 ovr_m;
    logic [17:0]        got_q [$];

    half_band_decim_2 dut (
        .clk     (clk),
        .reset   (reset),
        .clk_en  (clk_en),
        .x_in    (x_in),
        .y       (y),
        .y_valid (y_valid),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d want %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0b want %0b", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] ref_y();
        longint s;
        logic [17:0] r;
        s = longint'(hist[5]) * 65536
          + longint'(C1) * longint'(hist[4] + hist[6])
          + longint'(C3) * longint'(hist[2] + hist[8])
          + longint'(C5) * longint'(hist[0] + hist[10]);
        s = (s + 65536) >>> 17;
        if (s > 131071) s = 131071;
        if (s < -131072) s = -131072;
        r = s[17:0];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 11; k++) hist[k] = 0;
        ph_m   = 0;
        last_y = 18'sd0;
        ovr_m  = 1'b0;
    endtask

    // Reset for a few cycles (optionally with a strobe that must be ignored).
    task automatic do_reset(input bit with_en);
        @(negedge clk);
        reset  = 1'b1;
        clk_en = with_en;
        x_in   = 18'sd77777;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        clk_en = 1'b0;
        model_reset();
        chk("rst_y", y, 18'sd0);
        chk1("rst_y_valid", y_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_overrun", overrun, 1'b0);
    endtask

    // Present one sample, then check the next five edges cycle by cycle.
    // ovr_at / rst_at: edge index (1..5) at which to inject a strobe / reset.
    task automatic step(input int x, input int extra, input int ovr_at, input int rst_at);
        int          cur_ph;
        bit          abort;
        logic [17:0] exp_y;
        logic [17:0] xv;
        abort = 1'b0;
        xv    = 18'(x);
        @(negedge clk);
        x_in   = xv;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        for (int k = 10; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
        cur_ph  = ph_m;
        ph_m    = 1 - ph_m;
        exp_y   = ref_y();
        chk1("busy_after_accept", busy, cur_ph == 1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == ovr_at) begin
                clk_en = 1'b1;
                x_in   = 18'($urandom);
            end
            if (i == rst_at) reset = 1'b1;
            @(posedge clk);
            #1;
            clk_en = 1'b0;
            reset  = 1'b0;
            if (i == rst_at) begin
                model_reset();
                abort = 1'b1;
            end else if (i == ovr_at && cur_ph == 1 && !abort && i <= 4) begin
                ovr_m = 1'b1;
            end
            if (cur_ph == 1 && i == 5 && !abort) last_y = exp_y;
            chk1("y_valid", y_valid, cur_ph == 1 && i == 5 && !abort);
            chk1("busy", busy, cur_ph == 1 && i <= 3 && !abort);
            chk("y", y, last_y);
            chk1("overrun", overrun, ovr_m);
            if (y_valid) got_q.push_back(y);
        end
        repeat (extra) @(posedge clk);
    endtask

    initial begin
        int        imp1 [7];
        int        imp0 [6];
        int        satv [12];
        int        base;
        logic [17:0] e;

        imp1 = '{1311, -10486, 41943, 41943, -10486, 1311, 0};
        imp0 = '{0, 0, 65536, 0, 0, 0};
        satv = '{0, P, 0, N, 0, P, P, P, 0, N, 0, P};
        model_reset();

        // DC: 20 samples of 0.5 spaced 8 clocks.
        do_reset(1'b0);
        got_q.delete();
        for (int s = 0; s < 20; s++) step(65536, 2, 0, 0);
        chk("dc_count", 18'(got_q.size()), 18'd10);
        for (int s = 5; s < got_q.size(); s++) chk("dc_settled", got_q[s], 18'sd65536);

        // Impulse landing on a phase-1 sample.
        do_reset(1'b0);
        got_q.delete();
        step(0, 1, 0, 0);
        step(P, 1, 0, 0);
        for (int s = 0; s < 12; s++) step(0, 1, 0, 0);
        for (int s = 0; s < 7; s++) begin
            e = 18'(imp1[s]);
            chk("imp1", got_q[s], e);
        end

        // Impulse landing on a phase-0 sample; reset arrives with a strobe.
        do_reset(1'b1);
        got_q.delete();
        step(P, 1, 0, 0);
        for (int s = 0; s < 11; s++) step(0, 1, 0, 0);
        for (int s = 0; s < 6; s++) begin
            e = 18'(imp0[s]);
            chk("imp0", got_q[s], e);
        end

        // Positive and negative saturation.
        do_reset(1'b0);
        got_q.delete();
        for (int s = 0; s < 12; s++) step(satv[s], 0, 0, 0);
        chk("sat_pos", got_q[got_q.size()-1], 18'sd131071);
        do_reset(1'b0);
        got_q.delete();
        for (int s = 0; s < 12; s++) step(s == 0 ? 0 : -1 - satv[s], 0, 0, 0);
        chk("sat_neg", got_q[got_q.size()-1], -18'sd131072);

        // Random samples with random spacing.
        do_reset(1'b0);
        for (int s = 0; s < 40; s++) step(int'($signed(18'($urandom))), int'($urandom_range(0, 3)), 0, 0);

        // Overrun two edges after a phase-1 accept; sticky afterwards.
        do_reset(1'b0);
        for (int s = 0; s < 5; s++) step(int'($signed(18'($urandom))), 0, 0, 0);
        step(int'($signed(18'($urandom))), 0, 2, 0);
        base = got_q.size();
        for (int s = 0; s < 6; s++) step(int'($signed(18'($urandom))), 1, 0, 0);
        chk1("overrun_sticky", overrun, 1'b1);

        // Reset two edges after a phase-1 accept.
        do_reset(1'b0);
        step(1000, 0, 0, 0);
        step(50000, 0, 0, 2);
        chk1("midrst_overrun", overrun, 1'b0);
        step(90000, 0, 0, 0);
        step(-70000, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
